// File: rtl/accu_pkg.sv
// Shared types and helpers for the accumulator arbiter: defaults, FSM states
// and the round-robin winner search.
package accu_pkg;

    localparam int BURST_DEF = 4;
    localparam int RES_W_DEF = 10;
    localparam int MAX_REQ   = 8;
    localparam int RR_W      = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_LOCK = 1'b1
    } state_e;

    // First asserted valid searching upward from ptr+1 (mod n); ptr itself is checked last.
    function automatic logic [RR_W-1:0] rr_next(
        input logic [MAX_REQ-1:0] valid,
        input logic [RR_W-1:0]    ptr,
        input int                 n
    );
        logic [RR_W-1:0] win;
        logic            found;
        int              idx;
        win   = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= MAX_REQ; i++) begin
            idx = (int'(ptr) + i) % n;
            if ((i <= n) && !found && valid[idx]) begin
                win   = RR_W'(idx);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/accu_tag_fifo.sv
// Owner-tag FIFO: records which requester owns each group still awaiting
// its accumulator result. DEPTH must be a power of two, at least 2.
module accu_tag_fifo #(
    parameter int ID_W  = 2,
    parameter int DEPTH = 2,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push,
    input  logic [ID_W-1:0] din,
    input  logic            pop,
    output logic [ID_W-1:0] head,
    output logic [CW-1:0]   count,
    output logic            full,
    output logic            empty
);

    logic [ID_W-1:0] mem_q [DEPTH];
    logic [ID_W-1:0] mem_d [DEPTH];
    logic [AW-1:0]   wr_q, wr_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    // Next-state for storage, pointers and occupancy; pointers wrap naturally.
    always_comb begin
        mem_d = mem_q;
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (push) begin
            mem_d[wr_q] = din;
            wr_d        = wr_q + AW'(1'b1);
        end else begin
            wr_d = wr_q;
        end
        if (pop) begin
            rd_d = rd_q + AW'(1'b1);
        end else begin
            rd_d = rd_q;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + CW'(1'b1);
            2'b01:   cnt_d = cnt_q - CW'(1'b1);
            default: cnt_d = cnt_q;
        endcase
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    assign head  = mem_q[rd_q];
    assign count = cnt_q;
    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);

endmodule

// File: rtl/accu_arbiter.sv
// Shares one BURST-beat accumulator between N_REQ requesters: whole groups are
// granted round-robin and each result comes back tagged with its owner.
module accu_arbiter
    import accu_pkg::*;
#(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 8,
    parameter int RES_W     = RES_W_DEF,
    parameter int BURST     = BURST_DEF,
    parameter int TAG_DEPTH = 2,
    localparam int ID_W     = $clog2(N_REQ)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req_valid,
    output logic [N_REQ-1:0]        req_ready,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    output logic                    acc_valid,
    input  logic                    acc_ready,
    output logic [DATA_W-1:0]       acc_data,
    input  logic                    res_in_valid,
    output logic                    res_in_ready,
    input  logic [RES_W-1:0]        res_in_data,
    output logic                    res_out_valid,
    input  logic                    res_out_ready,
    output logic [RES_W-1:0]        res_out_data,
    output logic [ID_W-1:0]         res_out_id,
    output logic                    busy,
    output logic                    err_orphan
);

    localparam int CNT_W = $clog2(BURST);
    localparam int TC_W  = $clog2(TAG_DEPTH) + 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST - 1);

    state_e             state_q, state_d;
    logic [ID_W-1:0]    gnt_q, gnt_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_orphan_q, err_orphan_d;

    logic [MAX_REQ-1:0] valid_pad_s;
    logic [RR_W-1:0]    win_s;
    logic               sel_valid_s;
    logic [DATA_W-1:0]  sel_data_s;
    logic               push_s;
    logic               pop_s;
    logic [ID_W-1:0]    tag_head_s;
    logic [TC_W-1:0]    tag_count_s;
    logic               tag_full_s;
    logic               tag_empty_s;
    logic               tag_avail_s;

    // Widen the request vector so the shared round-robin helper sees a fixed width.
    always_comb begin
        valid_pad_s              = '0;
        valid_pad_s[N_REQ-1:0]   = req_valid;
        win_s                    = rr_next(valid_pad_s, RR_W'(ptr_q), N_REQ);
        sel_valid_s              = req_valid[gnt_q];
        sel_data_s               = req_data[int'(gnt_q)*DATA_W +: DATA_W];
    end

    // FSM next-state and the locked-group pass-through to the accumulator.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        push_s    = 1'b0;
        acc_valid = 1'b0;
        acc_data  = '0;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if ((|req_valid) && !tag_full_s) begin
                    gnt_d   = ID_W'(win_s);
                    state_d = ST_LOCK;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOCK: begin
                acc_valid        = sel_valid_s;
                acc_data         = sel_data_s;
                req_ready[gnt_q] = acc_ready;
                // The grant is held through owner stalls; only the last beat releases it.
                if (sel_valid_s && acc_ready) begin
                    if (cnt_q == LAST_BEAT) begin
                        push_s  = 1'b1;
                        ptr_d   = gnt_q;
                        cnt_d   = '0;
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1'b1);
                    end
                end else begin
                    cnt_d = cnt_q;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Result path is combinational; a result with no outstanding tag is refused.
    always_comb begin
        tag_avail_s   = (tag_count_s != '0);
        res_out_valid = res_in_valid && tag_avail_s;
        res_in_ready  = res_out_ready && tag_avail_s;
        pop_s         = res_in_valid && res_in_ready;
        res_out_data  = res_in_data;
        res_out_id    = tag_head_s;
        err_orphan_d  = err_orphan_q | (res_in_valid & tag_empty_s);
    end

    // State registers; the pointer starts at N_REQ-1 so requester 0 wins first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gnt_q        <= '0;
            ptr_q        <= ID_W'(N_REQ - 1);
            cnt_q        <= '0;
            err_orphan_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            ptr_q        <= ptr_d;
            cnt_q        <= cnt_d;
            err_orphan_q <= err_orphan_d;
        end
    end

    assign busy       = (state_q == ST_LOCK);
    assign err_orphan = err_orphan_q;

    accu_tag_fifo #(
        .ID_W  (ID_W),
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (gnt_q),
        .pop   (pop_s),
        .head  (tag_head_s),
        .count (tag_count_s),
        .full  (tag_full_s),
        .empty (tag_empty_s)
    );

endmodule

// File: tb/tb_accu_arbiter.sv
// Bench for accu_arbiter: directed scenarios plus random traffic, all checked
// cycle by cycle against a queue-based model of grants, tags and results.
module tb_accu_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [31:0] req_data;
    logic        acc_valid;
    logic        acc_ready;
    logic [7:0]  acc_data;
    logic        res_in_valid;
    logic        res_in_ready;
    logic [9:0]  res_in_data;
    logic        res_out_valid;
    logic        res_out_ready;
    logic [9:0]  res_out_data;
    logic [1:0]  res_out_id;
    logic        busy;
    logic        err_orphan;

    always #5 clk = ~clk;

    accu_arbiter dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_data      (req_data),
        .acc_valid     (acc_valid),
        .acc_ready     (acc_ready),
        .acc_data      (acc_data),
        .res_in_valid  (res_in_valid),
        .res_in_ready  (res_in_ready),
        .res_in_data   (res_in_data),
        .res_out_valid (res_out_valid),
        .res_out_ready (res_out_ready),
        .res_out_data  (res_out_data),
        .res_out_id    (res_out_id),
        .busy          (busy),
        .err_orphan    (err_orphan)
    );

    int total = 0;
    int bad   = 0;

    // reference model: group ownership, outstanding tags, orphan flag
    bit m_lock;
    int m_owner;
    int m_beats;
    int m_ptr;
    int m_tags[$];
    bit m_orphan;

    // accumulator stand-in and observation logs
    int a_sum;
    int a_n;
    int res_pend[$];
    bit auto_res;
    int own_log[$];
    int len_log[$];
    int pop_log[$];
    bit prev_busy;
    int run_len;
    int last_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int qget(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic do_reset();
        rst_n         = 1'b0;
        req_valid     = 4'd0;
        req_data      = 32'd0;
        acc_ready     = 1'b0;
        res_in_valid  = 1'b0;
        res_in_data   = 10'd0;
        res_out_ready = 1'b0;
        auto_res      = 1'b0;
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_acc_valid", 32'(acc_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_res_in_ready", 32'(res_in_ready), 32'd0);
        chk("rst_res_out_valid", 32'(res_out_valid), 32'd0);
        chk("rst_err_orphan", 32'(err_orphan), 32'd0);
        m_lock = 1'b0; m_beats = 0; m_ptr = 3; m_owner = 0; m_orphan = 1'b0;
        m_tags.delete();
        a_sum = 0; a_n = 0;
        res_pend.delete(); own_log.delete(); len_log.delete(); pop_log.delete();
        prev_busy = 1'b0; run_len = 0; last_data = -1;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // One clock: drive results, compare every output with the model, advance the model.
    task automatic cycle();
        logic [3:0] e_rr;
        logic       e_av;
        int         sz;
        int         own;
        bit         hs;
        bit         pop;
        bit         found;
        int         idx;
        if (auto_res) begin
            res_in_valid = (res_pend.size() > 0);
            res_in_data  = (res_pend.size() > 0) ? 10'(res_pend[0]) : 10'd0;
        end
        #2;
        sz   = m_tags.size();
        e_av = m_lock ? req_valid[m_owner] : 1'b0;
        e_rr = (m_lock && acc_ready) ? (4'b0001 << m_owner) : 4'b0000;
        chk("busy", 32'(busy), 32'(m_lock));
        chk("acc_valid", 32'(acc_valid), 32'(e_av));
        chk("req_ready", 32'(req_ready), 32'(e_rr));
        if (e_av) chk("acc_data", 32'(acc_data), 32'(req_data[m_owner*8 +: 8]));
        chk("res_out_valid", 32'(res_out_valid), 32'(res_in_valid && (sz > 0)));
        chk("res_in_ready", 32'(res_in_ready), 32'(res_out_ready && (sz > 0)));
        if (sz > 0) chk("res_out_id", 32'(res_out_id), 32'(m_tags[0]));
        chk("res_out_data", 32'(res_out_data), 32'(res_in_data));
        chk("err_orphan", 32'(err_orphan), 32'(m_orphan));

        if (busy && !prev_busy) begin
            own = -1;
            for (int k = 0; k < 4; k++) if (req_ready[k]) own = k;
            own_log.push_back(own);
            run_len = 0;
        end
        if (busy) run_len++;
        else if (prev_busy) len_log.push_back(run_len);
        prev_busy = busy;
        if (res_out_valid && res_out_ready) begin
            pop_log.push_back(int'(res_out_id));
            last_data = int'(res_out_data);
        end

        hs  = e_av && acc_ready;
        pop = res_in_valid && res_out_ready && (sz > 0);
        if (res_in_valid && (sz == 0)) m_orphan = 1'b1;
        if (pop) void'(m_tags.pop_front());
        if (pop && auto_res) void'(res_pend.pop_front());
        if (hs) begin
            a_sum += int'(req_data[m_owner*8 +: 8]);
            a_n++;
            if (a_n == 4) begin
                res_pend.push_back(a_sum);
                a_sum = 0;
                a_n   = 0;
            end
        end
        if (m_lock) begin
            if (hs) begin
                m_beats++;
                if (m_beats == 4) begin
                    m_tags.push_back(m_owner);
                    m_ptr   = m_owner;
                    m_lock  = 1'b0;
                    m_beats = 0;
                end
            end
        end else if ((req_valid != 4'd0) && (sz < 2)) begin
            found = 1'b0;
            for (int k = 1; k <= 4; k++) begin
                idx = (m_ptr + k) % 4;
                if (!found && req_valid[idx]) begin
                    m_owner = idx;
                    found   = 1'b1;
                end
            end
            m_lock = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int samp[4];
        int exp_rr[5];
        samp   = '{10, 20, 30, 40};
        exp_rr = '{0, 1, 2, 3, 0};

        // single requester, happy path
        do_reset();
        acc_ready = 1'b1; res_out_ready = 1'b1; auto_res = 1'b1;
        req_valid = 4'b0100;
        req_data[16 +: 8] = 8'd10;
        cycle();
        for (int b = 0; b < 4; b++) begin
            req_data[16 +: 8] = 8'(samp[b]);
            cycle();
        end
        req_valid = 4'd0;
        repeat (3) cycle();
        chk("happy_owner", 32'(qget(own_log, 0)), 32'd2);
        chk("happy_len", 32'(qget(len_log, 0)), 32'd4);
        chk("happy_sum", 32'(last_data), 32'd100);
        chk("happy_id", 32'(qget(pop_log, 0)), 32'd2);

        // round-robin after reset with everyone requesting
        do_reset();
        acc_ready = 1'b1; res_out_ready = 1'b1; auto_res = 1'b1;
        req_valid = 4'hF;
        repeat (26) begin
            req_data = $urandom;
            cycle();
        end
        for (int i = 0; i < 5; i++) chk("rr_order", 32'(qget(own_log, i)), 32'(exp_rr[i]));
        for (int i = 0; i < 4; i++) chk("rr_len", 32'(qget(len_log, i)), 32'd4);

        // owner 1 stalls mid-group while 3 waits
        do_reset();
        acc_ready = 1'b1; res_out_ready = 1'b1; auto_res = 1'b1;
        req_valid = 4'b1010;
        req_data  = $urandom;
        repeat (3) cycle();
        req_valid = 4'b1000;
        repeat (5) begin
            cycle();
            chk("stall_busy", 32'(busy), 32'd1);
            chk("stall_rr3", 32'(req_ready[3]), 32'd0);
        end
        req_valid = 4'b1010;
        repeat (4) cycle();
        chk("stall_owner", 32'(qget(own_log, 0)), 32'd1);
        chk("stall_len", 32'(qget(len_log, 0)), 32'd9);
        chk("stall_next", 32'(qget(own_log, 1)), 32'd3);

        // tag FIFO full blocks new grants until results drain
        do_reset();
        acc_ready = 1'b1; res_out_ready = 1'b0; auto_res = 1'b1;
        req_valid = 4'b0011;
        repeat (16) begin
            req_data = $urandom;
            cycle();
        end
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_groups", 32'(own_log.size()), 32'd2);
        chk("full_valid", 32'(res_out_valid), 32'd1);
        chk("full_id", 32'(res_out_id), 32'd0);
        res_out_ready = 1'b1;
        repeat (8) cycle();
        chk("full_pop0", 32'(qget(pop_log, 0)), 32'd0);
        chk("full_pop1", 32'(qget(pop_log, 1)), 32'd1);
        chk("full_resume", 32'(qget(own_log, 2)), 32'd0);

        // orphan result, then reset in the middle of a group
        do_reset();
        res_in_valid = 1'b1; res_in_data = 10'd5;
        cycle();
        chk("orph_ready", 32'(res_in_ready), 32'd0);
        chk("orph_flag", 32'(err_orphan), 32'd1);
        res_in_valid = 1'b0;
        acc_ready = 1'b1; res_out_ready = 1'b1;
        req_valid = 4'b0110;
        repeat (3) cycle();
        chk("orph_sticky", 32'(err_orphan), 32'd1);
        chk("mid_busy", 32'(busy), 32'd1);
        do_reset();
        acc_ready = 1'b1; res_out_ready = 1'b1; auto_res = 1'b1;
        req_valid = 4'hF;
        repeat (2) cycle();
        chk("post_rst_owner", 32'(qget(own_log, 0)), 32'd0);

        // random traffic against the model
        do_reset();
        auto_res = 1'b1;
        repeat (600) begin
            req_valid     = 4'($urandom);
            req_data      = $urandom;
            acc_ready     = ($urandom_range(3) != 0);
            res_out_ready = ($urandom_range(1) != 0);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/accu_arbiter.md
Name: accu_arbiter

Overview:
- Shares one 4-beat accumulator (8-bit in, 10-bit sum out, valid/ready on both sides) between N_REQ upstream requesters.
- Grants the accumulator input to one requester for a full BURST-beat group, with round-robin arbitration between groups.
- Records the owner of each completed group in a tag FIFO, so each accumulator result returns tagged with its requester ID.
- Sits between the sample producers and the accumulator; the accumulator itself is unchanged.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, sample width.
- RES_W, 10, accumulator result width.
- BURST, 4, beats per group; must match the accumulator group size.
- TAG_DEPTH, 2, owner-tag FIFO depth (power of 2); this is the maximum number of groups awaiting a result.
- ID_W, derived as clog2(N_REQ); not overridable.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  N_REQ  per-requester sample valid
- req_ready  out  N_REQ  per-requester ready
- req_data  in  N_REQ*DATA_W  packed samples; requester i occupies bits [i*DATA_W +: DATA_W]
- acc_valid  out  1  sample valid to accumulator
- acc_ready  in  1  accumulator ready
- acc_data  out  DATA_W  sample to accumulator
- res_in_valid  in  1  accumulator result valid
- res_in_ready  out  1  result accept
- res_in_data  in  RES_W  accumulator sum
- res_out_valid  out  1  tagged result valid
- res_out_ready  in  1  consumer ready
- res_out_data  out  RES_W  sum, passed through from res_in_data
- res_out_id  out  ID_W  owning requester
- busy  out  1  high while a group is locked
- err_orphan  out  1  sticky; set when a result arrives with no outstanding tag

Behaviour:
- Reset (async):
  - FSM goes to IDLE; beat counter 0; tag FIFO emptied.
  - Round-robin pointer set to N_REQ-1, so requester 0 has top priority first.
  - busy=0 and err_orphan=0. All ready/valid outputs are 0 because they are combinational from this state.
- FSM state IDLE:
  - acc_valid=0 and all req_ready=0.
  - Arbitration happens when at least one req_valid is high and tag count < TAG_DEPTH.
  - Winner is the first asserted req_valid searching upward from pointer+1 mod N_REQ.
  - The winner is registered as gnt and the FSM moves to LOCK on the next edge. Arbitration-to-first-beat latency is 1 cycle.
- FSM state LOCK:
  - Zero-latency combinational pass-through: acc_valid=req_valid[gnt], acc_data=req_data[gnt], req_ready[gnt]=acc_ready. All other req_ready=0.
  - Beat counter increments on each acc_valid&&acc_ready.
  - The grant stays held if the owner drops valid mid-group; there is no timeout and no preemption.
  - On the handshake of beat BURST-1:
    - push gnt into the tag FIFO;
    - set pointer=gnt;
    - clear the counter;
    - return to IDLE.
  - There is a minimum of 1 IDLE cycle between groups.
- busy=1 exactly in LOCK.
- Result path, all combinational:
  - res_out_valid = res_in_valid && tag_count>0.
  - res_in_ready = res_out_ready && tag_count>0.
  - res_out_id = FIFO head. Pop on res_in_valid&&res_in_ready.
- Tag FIFO:
  - Push and pop in the same cycle leaves the count unchanged.
  - A push can never overflow, because a grant requires count<TAG_DEPTH and only one group is in flight.
  - When full (count==TAG_DEPTH), no new grant is issued until a pop occurs.
- Orphan result: res_in_valid with an empty FIFO is not accepted (res_in_ready=0) and sets err_orphan. err_orphan clears only on reset.
- Reset mid-group: partial beats are abandoned, with no push. The accumulator must be reset by the same rst_n.

Decomposition:
- Shared package accu_pkg holds:
  - the BURST default and RES_W;
  - the FSM state enum {IDLE, LOCK};
  - a function computing the round-robin next-grant from (valid vector, pointer).
- One sub-module: accu_tag_fifo, a sync FIFO of ID_W x TAG_DEPTH with push, pop, head, count, full and empty.

Test Plan:
- Single requester, happy path:
  - Stimulus: requester 2 only, with samples 10,20,30,40; acc_ready=1.
  - Response: gnt=2 one cycle after valid; 4 consecutive acc beats; return to IDLE.
  - Result: result 100 appears with res_out_id=2.
- Round-robin after reset:
  - Stimulus: all 4 requesters continuously valid.
  - Response: groups are granted in order 0,1,2,3,0.
  - Response: each group is exactly 4 beats, with 1 idle cycle between groups.
- Mid-group stall:
  - Stimulus: owner 1 drops valid after beat 2 for 5 cycles; requester 3 valid throughout.
  - Response: busy stays 1 and req_ready[3]=0 throughout the stall.
  - Response: group completes with owner 1 only.
- Tag FIFO full:
  - Stimulus: res_out_ready=0; requesters 0 and 1 valid.
  - Response: after 2 completed groups, no new grant is issued.
  - Response: when res_out_ready=1, tags 0 and 1 pop in order and granting resumes.
- Orphan result and reset mid-group:
  - Stimulus: res_in_valid with an empty FIFO.
  - Response: res_in_ready=0 and err_orphan=1.
  - Stimulus: assert rst_n=0 after beat 2.
  - Response: all outputs clear and err_orphan=0.
  - Response: the next grant goes to requester 0.
